// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline constants and types.
// Used by the hazard controller and the stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

  localparam int TRK_AW       = 8;
  localparam int DEF_DEPTH    = 3;
  localparam int DEF_LOAD_LAT = 2;
  localparam int DEF_BR_STAGE = 2;

  typedef struct packed {
    logic              vld;
    logic [TRK_AW-1:0] dst;
    logic              is_load;
  } trk_t;

  function automatic int fwd_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-side hazard bundle: decode info in,
// stall/flush/forward controls out.
interface pipe_hazard_ctrl_if
  import pipe_pkg::*;
#(
  parameter int NREG  = 16,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = 16
);
  localparam int AW = $clog2(NREG);
  localparam int FW = fwd_w(DEPTH);

  logic          id_valid;
  logic [AW-1:0] id_src0;
  logic [AW-1:0] id_src1;
  logic          id_src0_vld;
  logic          id_src1_vld;
  logic [AW-1:0] id_dst;
  logic          id_we;
  logic          id_is_load;
  logic          id_hlt;
  logic          br_taken;
  logic          stall;
  logic          bubble_ex;
  logic          flush;
  logic [FW-1:0] fwd_sel0;
  logic [FW-1:0] fwd_sel1;
  logic          pc_freeze;
  logic          hlt;
  logic [CW-1:0] stall_cnt;

  modport master (
    output id_valid, id_src0, id_src1,
    output id_src0_vld, id_src1_vld,
    output id_dst, id_we, id_is_load,
    output id_hlt, br_taken,
    input  stall, bubble_ex, flush,
    input  fwd_sel0, fwd_sel1,
    input  pc_freeze, hlt, stall_cnt
  );

  modport slave (
    input  id_valid, id_src0, id_src1,
    input  id_src0_vld, id_src1_vld,
    input  id_dst, id_we, id_is_load,
    input  id_hlt, br_taken,
    output stall, bubble_ex, flush,
    output fwd_sel0, fwd_sel1,
    output pc_freeze, hlt, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// Youngest-producer priority encoder for one
// source operand against the in-flight tracker.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int AW       = 4,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int ZERO_REG = 1,
  parameter int FW       = fwd_w(DEPTH)
) (
  input  logic [AW-1:0]    src,
  input  logic             src_vld,
  input  trk_t [DEPTH:1]   trk,
  output logic [FW-1:0]    sel,
  output logic             ld_hit
);

  logic [TRK_AW-1:0] src_x;
  logic              live;

  always_comb begin
    src_x  = TRK_AW'(src);
    live   = src_vld & ~((ZERO_REG != 0) && (src == '0));
    sel    = '0;
    ld_hit = 1'b0;
    // oldest first so the youngest match wins
    for (int k = DEPTH; k >= 1; k--) begin
      if (live && trk[k].vld && trk[k].dst == src_x) begin
        sel    = FW'(k);
        ld_hit = trk[k].is_load && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and halt-drain controller
// for the five-stage pipeline.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NREG     = 16,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int BR_STAGE = DEF_BR_STAGE,
  parameter int ZERO_REG = 1,
  parameter int CW       = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int AW = $clog2(NREG);
  localparam int FW = fwd_w(DEPTH);

  state_t         state, state_nx;
  trk_t [DEPTH:1] trk, trk_nx;
  trk_t           ins;
  logic [CW-1:0]  cnt;
  logic [FW-1:0]  sel0, sel1;
  logic           ld0, ld1;
  logic           run, flush, stall;
  logic           wr_ok, all_idle;

  hazard_match #(
    .AW(AW), .DEPTH(DEPTH),
    .LOAD_LAT(LOAD_LAT),
    .ZERO_REG(ZERO_REG), .FW(FW)
  ) u_m0 (
    .src(hz.id_src0),
    .src_vld(hz.id_src0_vld),
    .trk(trk),
    .sel(sel0),
    .ld_hit(ld0)
  );

  hazard_match #(
    .AW(AW), .DEPTH(DEPTH),
    .LOAD_LAT(LOAD_LAT),
    .ZERO_REG(ZERO_REG), .FW(FW)
  ) u_m1 (
    .src(hz.id_src1),
    .src_vld(hz.id_src1_vld),
    .trk(trk),
    .sel(sel1),
    .ld_hit(ld1)
  );

  assign run   = (state == RUN);
  assign flush = hz.br_taken;
  assign stall = hz.id_valid & run & ~flush
               & (ld0 | ld1);

  always_comb begin
    all_idle = 1'b1;
    for (int k = 1; k <= DEPTH; k++)
      if (trk[k].vld) all_idle = 1'b0;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:
        if (hz.id_valid & hz.id_hlt
            & ~stall & ~flush)
          state_nx = DRAIN;
      DRAIN:
        if (flush)         state_nx = RUN;
        else if (all_idle) state_nx = HALTED;
      HALTED:  state_nx = HALTED;
      default: state_nx = RUN;
    endcase
  end

  always_comb begin
    wr_ok = hz.id_we
          & ~((ZERO_REG != 0) && (hz.id_dst == '0));
    ins = '{
      vld:     hz.id_valid & wr_ok & run
               & ~stall & ~flush,
      dst:     TRK_AW'(hz.id_dst),
      is_load: hz.id_is_load
    };
    trk_nx    = trk;
    trk_nx[1] = ins;
    // wrong-path instructions younger than the branch die
    for (int k = 2; k <= DEPTH; k++) begin
      trk_nx[k] = trk[k-1];
      if (flush && k <= BR_STAGE)
        trk_nx[k].vld = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      trk   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      trk   <= trk_nx;
      if (stall && cnt != '1)
        cnt <= cnt + CW'(1);
    end
  end

  assign hz.stall     = stall;
  assign hz.bubble_ex = stall | ~run;
  assign hz.flush     = flush;
  assign hz.fwd_sel0  = sel0;
  assign hz.fwd_sel1  = sel1;
  assign hz.pc_freeze = ~run;
  assign hz.hlt       = (state == HALTED);
  assign hz.stall_cnt = cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed table
// plus randomized run against a pipeline model.
module tb_pipe_hazard_ctrl;

  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 2;
  localparam int BR_STAGE = 2;

  typedef struct packed {
    logic       vld;
    logic [3:0] s0;
    logic       v0;
    logic [3:0] s1;
    logic       v1;
    logic [3:0] dst;
    logic       we;
    logic       ld;
    logic       hl;
    logic       br;
  } in_t;

  typedef struct {
    logic       rst;
    in_t        i;
    logic       c;
    logic       st, bu, fl;
    logic [1:0] f0, f1;
    logic       fz, hl;
    int         cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(
    .NREG(16), .DEPTH(DEPTH), .CW(16)
  ) bus ();

  pipe_hazard_ctrl #(
    .NREG(16), .DEPTH(DEPTH),
    .LOAD_LAT(LOAD_LAT), .BR_STAGE(BR_STAGE),
    .ZERO_REG(1), .CW(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hz(bus)
  );

  int   n_chk = 0;
  int   n_pass = 0;
  vec_t tbl[$];
  in_t  cur;
  logic cur_rst;

  // pipeline model: destination per stage, -1 = nothing writing
  int m_dst[1:DEPTH];
  bit m_ld[1:DEPTH];
  int m_mode;
  int m_cnt;
  bit e_st, e_bu, e_fl, e_fz, e_hl;
  int e_f0, e_f1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, act, exp);
  endtask

  function automatic in_t mk(
    input logic vld, input int s0, input logic v0,
    input int s1, input logic v1, input int dst,
    input logic we, input logic ld,
    input logic hl, input logic br);
    in_t r;
    r.vld = vld; r.s0 = 4'(s0); r.v0 = v0;
    r.s1 = 4'(s1); r.v1 = v1; r.dst = 4'(dst);
    r.we = we; r.ld = ld; r.hl = hl; r.br = br;
    return r;
  endfunction

  task automatic row(
    input logic rst, input in_t i, input logic c,
    input logic st, input logic bu, input logic fl,
    input int f0, input int f1,
    input logic fz, input logic hl, input int cnt);
    vec_t v;
    v.rst = rst; v.i = i; v.c = c;
    v.st = st; v.bu = bu; v.fl = fl;
    v.f0 = 2'(f0); v.f1 = 2'(f1);
    v.fz = fz; v.hl = hl; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  function automatic int youngest(input int s,
                                  input bit sv);
    if (!sv || s == 0) return 0;
    for (int k = 1; k <= DEPTH; k++)
      if (m_dst[k] == s) return k;
    return 0;
  endfunction

  task automatic model_eval();
    bit lu;
    e_f0 = youngest(int'(cur.s0), cur.v0);
    e_f1 = youngest(int'(cur.s1), cur.v1);
    lu = (e_f0 != 0 && m_ld[e_f0] && e_f0 < LOAD_LAT)
      || (e_f1 != 0 && m_ld[e_f1] && e_f1 < LOAD_LAT);
    e_fl = cur.br;
    e_st = cur.vld && m_mode == 0 && !cur.br && lu;
    e_bu = e_st || m_mode != 0;
    e_fz = m_mode != 0;
    e_hl = m_mode == 2;
  endtask

  task automatic drive(input logic rst, input in_t i);
    cur = i; cur_rst = rst;
    rst_n           = rst;
    bus.id_valid    = i.vld;
    bus.id_src0     = i.s0;
    bus.id_src0_vld = i.v0;
    bus.id_src1     = i.s1;
    bus.id_src1_vld = i.v1;
    bus.id_dst      = i.dst;
    bus.id_we       = i.we;
    bus.id_is_load  = i.ld;
    bus.id_hlt      = i.hl;
    bus.br_taken    = i.br;
    #2;
  endtask

  task automatic tick();
    bit empty;
    int nmode;
    model_eval();
    @(posedge clk);
    if (!cur_rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        m_dst[k] = -1; m_ld[k] = 0;
      end
      m_mode = 0; m_cnt = 0;
    end else begin
      empty = 1;
      for (int k = 1; k <= DEPTH; k++)
        if (m_dst[k] >= 0) empty = 0;
      nmode = m_mode;
      if (m_mode == 0 && cur.vld && cur.hl
          && !e_st && !cur.br) nmode = 1;
      else if (m_mode == 1 && cur.br) nmode = 0;
      else if (m_mode == 1 && empty) nmode = 2;
      if (e_st && m_cnt < 65535) m_cnt++;
      for (int k = DEPTH; k >= 2; k--) begin
        m_dst[k] = m_dst[k-1]; m_ld[k] = m_ld[k-1];
        if (cur.br && k <= BR_STAGE) m_dst[k] = -1;
      end
      m_dst[1] = (m_mode == 0 && cur.vld && cur.we
                  && cur.dst != 0 && !e_st && !cur.br)
                 ? int'(cur.dst) : -1;
      m_ld[1] = cur.ld;
      m_mode = nmode;
    end
    #1;
  endtask

  initial begin
    in_t  z;
    in_t  r;
    logic rr;
    z = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      m_dst[k] = -1; m_ld[k] = 0;
    end
    m_mode = 0; m_cnt = 0;

    // forward ages, load-use, r0, flush over load-use
    row(0, z, 0, 0,0,0, 0,0, 0,0, 0);
    row(1, mk(1,0,0,0,0,3,1,0,0,0), 1, 0,0,0, 0,0, 0,0, 0);
    row(1, mk(1,3,1,0,0,0,0,0,0,0), 1, 0,0,0, 1,0, 0,0, 0);
    row(1, mk(1,3,1,0,0,0,0,0,0,0), 1, 0,0,0, 2,0, 0,0, 0);
    row(1, mk(1,3,1,0,0,5,1,1,0,0), 1, 0,0,0, 3,0, 0,0, 0);
    row(1, mk(1,0,0,5,1,6,1,0,0,0), 1, 1,1,0, 0,0, 0,0, 0);
    row(1, mk(1,0,0,5,1,6,1,0,0,0), 1, 0,0,0, 0,2, 0,0, 1);
    row(1, mk(1,0,1,6,1,0,1,0,0,0), 1, 0,0,0, 0,1, 0,0, 1);
    row(1, mk(1,0,1,6,1,7,1,1,0,0), 1, 0,0,0, 0,2, 0,0, 1);
    row(1, mk(1,7,1,6,1,0,0,0,0,1), 1, 0,0,1, 1,3, 0,0, 1);
    row(1, mk(1,7,1,6,1,0,0,0,0,0), 1, 0,0,0, 0,0, 0,0, 1);
    // halt with three older writers in flight
    row(1, mk(1,0,0,0,0,1,1,0,0,0), 1, 0,0,0, 0,0, 0,0, 1);
    row(1, mk(1,0,0,0,0,2,1,0,0,0), 1, 0,0,0, 0,0, 0,0, 1);
    row(1, mk(1,0,0,0,0,4,1,0,0,0), 1, 0,0,0, 0,0, 0,0, 1);
    row(1, mk(1,0,0,0,0,0,0,0,1,0), 1, 0,0,0, 0,0, 0,0, 1);
    row(1, mk(1,4,1,0,0,0,0,0,0,0), 1, 0,1,0, 2,0, 1,0, 1);
    row(1, z, 1, 0,1,0, 0,0, 1,0, 1);
    row(1, z, 1, 0,1,0, 0,0, 1,0, 1);
    row(1, z, 1, 0,1,0, 0,0, 1,1, 1);
    row(1, mk(0,0,0,0,0,0,0,0,0,1), 1, 0,1,1, 0,0, 1,1, 1);
    row(1, z, 1, 0,1,0, 0,0, 1,1, 1);
    // seven stalls, drain cancelled, reset mid-drain
    row(0, z, 0, 0,0,0, 0,0, 0,0, 0);
    row(1, z, 1, 0,0,0, 0,0, 0,0, 0);
    for (int i = 0; i < 7; i++) begin
      row(1, mk(1,0,0,0,0,5,1,1,0,0), 1, 0,0,0, 0,0, 0,0, i);
      row(1, mk(1,0,0,5,1,0,0,0,0,0), 1, 1,1,0, 0,0, 0,0, i);
      row(1, mk(1,0,0,5,1,0,0,0,0,0), 1, 0,0,0, 0,2, 0,0, i+1);
    end
    row(1, mk(1,0,0,0,0,0,0,0,1,0), 1, 0,0,0, 0,0, 0,0, 7);
    row(1, mk(0,0,0,0,0,0,0,0,0,1), 1, 0,1,1, 0,0, 1,0, 7);
    row(1, z, 1, 0,0,0, 0,0, 0,0, 7);
    row(1, mk(1,0,0,0,0,0,0,0,1,0), 1, 0,0,0, 0,0, 0,0, 7);
    row(0, mk(1,5,1,5,1,0,0,0,0,0), 1, 0,1,0, 0,0, 1,0, 7);
    row(1, mk(1,5,1,5,1,0,0,0,0,0), 1, 0,0,0, 0,0, 0,0, 0);

    foreach (tbl[n]) begin
      drive(tbl[n].rst, tbl[n].i);
      if (tbl[n].c) begin
        chk($sformatf("r%0d.stall", n), 32'(bus.stall), 32'(tbl[n].st));
        chk($sformatf("r%0d.bubble", n), 32'(bus.bubble_ex), 32'(tbl[n].bu));
        chk($sformatf("r%0d.flush", n), 32'(bus.flush), 32'(tbl[n].fl));
        chk($sformatf("r%0d.freeze", n), 32'(bus.pc_freeze), 32'(tbl[n].fz));
        chk($sformatf("r%0d.hlt", n), 32'(bus.hlt), 32'(tbl[n].hl));
        chk($sformatf("r%0d.cnt", n), 32'(bus.stall_cnt), 32'(tbl[n].cnt));
        if (!tbl[n].st) begin
          chk($sformatf("r%0d.fwd0", n), 32'(bus.fwd_sel0), 32'(tbl[n].f0));
          chk($sformatf("r%0d.fwd1", n), 32'(bus.fwd_sel1), 32'(tbl[n].f1));
        end
      end
      tick();
    end

    for (int n = 0; n < 3000; n++) begin
      r.vld = $urandom_range(0, 9) != 0;
      r.s0  = 4'($urandom_range(0, 3));
      r.v0  = $urandom_range(0, 3) != 0;
      r.s1  = 4'($urandom_range(0, 3));
      r.v1  = $urandom_range(0, 3) != 0;
      r.dst = 4'($urandom_range(0, 3));
      r.we  = $urandom_range(0, 9) < 7;
      r.ld  = $urandom_range(0, 9) < 4;
      r.hl  = $urandom_range(0, 29) == 0;
      r.br  = $urandom_range(0, 9) == 0;
      rr = (n != 0) && ($urandom_range(0, 119) != 0);
      drive(rr, r);
      model_eval();
      chk($sformatf("rnd%0d.stall", n), 32'(bus.stall), 32'(e_st));
      chk($sformatf("rnd%0d.bubble", n), 32'(bus.bubble_ex), 32'(e_bu));
      chk($sformatf("rnd%0d.flush", n), 32'(bus.flush), 32'(e_fl));
      chk($sformatf("rnd%0d.freeze", n), 32'(bus.pc_freeze), 32'(e_fz));
      chk($sformatf("rnd%0d.hlt", n), 32'(bus.hlt), 32'(e_hl));
      chk($sformatf("rnd%0d.cnt", n), 32'(bus.stall_cnt), 32'(m_cnt));
      if (!e_st) begin
        chk($sformatf("rnd%0d.fwd0", n), 32'(bus.fwd_sel0), 32'(e_f0));
        chk($sformatf("rnd%0d.fwd1", n), 32'(bus.fwd_sel1), 32'(e_f1));
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
